// File: rtl/br_comp.sv
// rtl/br_comp.sv - 32-bit branch comparator with registered debug/trace copies of the flags
module br_comp (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_br_un,
    output logic        o_br_less,
    output logic        o_br_equal,
    output logic        o_br_less_q,
    output logic        o_br_equal_q
);

    // {lt, eq} for an unsigned 4-bit magnitude compare, scanned MSB first
    function automatic logic [1:0] slice_cmp(input logic [3:0] a, input logic [3:0] b);
        logic lt;
        logic eq;
        lt = 1'b0;
        eq = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            lt = lt | (eq & ~a[i] & b[i]);
            eq = eq & ~(a[i] ^ b[i]);
        end
        return {lt, eq};
    endfunction

    // Merge two adjacent {lt, eq} pairs; the higher-order pair dominates
    function automatic logic [1:0] merge(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    logic [1:0] lvl0 [8];
    logic [1:0] lvl1 [4];
    logic [1:0] lvl2 [2];
    logic [1:0] lvl3;
    logic       ult;
    logic       sign_diff;

    // Leaf slices: eight 4-bit unsigned compares
    always_comb begin
        for (int s = 0; s < 8; s++) begin
            lvl0[s] = slice_cmp(i_rs1_data[4*s +: 4], i_rs2_data[4*s +: 4]);
        end
    end

    // Reduction tree toward the MSB: 8 -> 4 -> 2 -> 1
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            lvl1[n] = merge(lvl0[2*n+1], lvl0[2*n]);
        end
        for (int n = 0; n < 2; n++) begin
            lvl2[n] = merge(lvl1[2*n+1], lvl1[2*n]);
        end
        lvl3 = merge(lvl2[1], lvl2[0]);
    end

    // Sign correction: with matching sign bits the 32-bit unsigned result equals the
    // compare of bits [30:0]; with differing sign bits the negative operand is lesser
    always_comb begin
        ult        = lvl3[1];
        sign_diff  = i_rs1_data[31] ^ i_rs2_data[31];
        o_br_equal = lvl3[0];
        if (i_br_un || !sign_diff) begin
            o_br_less = ult;
        end else begin
            o_br_less = i_rs1_data[31];
        end
    end

    // Registered copies of the flags for debug and trace
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_br_less_q  <= 1'b0;
            o_br_equal_q <= 1'b0;
        end else begin
            o_br_less_q  <= o_br_less;
            o_br_equal_q <= o_br_equal;
        end
    end

endmodule

// File: tb/tb_br_comp.sv
// tb/tb_br_comp.sv - table-driven self-checking bench for br_comp
module tb_br_comp;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        br_un;
    logic        less;
    logic        equal;
    logic        less_q;
    logic        equal_q;

    int total;
    int bad;

    typedef struct {
        logic        un;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_less;
        logic        exp_eq;
    } vec_t;

    vec_t vecs[$];

    br_comp dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rs1_data   (rs1),
        .i_rs2_data   (rs2),
        .i_br_un      (br_un),
        .o_br_less    (less),
        .o_br_equal   (equal),
        .o_br_less_q  (less_q),
        .o_br_equal_q (equal_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic un, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.un     = un;
        v.a      = a;
        v.b      = b;
        v.exp_eq = (a == b);
        if (un) v.exp_less = (a < b);
        else    v.exp_less = ($signed(a) < $signed(b));
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rs1   = 32'h0;
        rs2   = 32'h0;
        br_un = 1'b1;

        // hand-computed directed vectors
        vecs.push_back('{1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h80000005, 32'h00000005, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h80000005, 32'h00000005, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h00000005, 32'h80000005, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h12345679, 32'h12345678, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h12345678, 32'h12345679, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h0000F000, 32'h00010000, 1'b1, 1'b0});
        // random sweep: 5 unsigned, 10 signed, expectations from the model
        for (int i = 0; i < 5; i++) vecs.push_back(model(1'b1, $urandom, $urandom));
        for (int i = 0; i < 10; i++) vecs.push_back(model(1'b0, $urandom, $urandom));

        // combinational checks are independent of clock and reset
        for (int i = 0; i < vecs.size(); i++) begin
            rs1   = vecs[i].a;
            rs2   = vecs[i].b;
            br_un = vecs[i].un;
            #1;
            check($sformatf("less[%0d] un=%b a=%h b=%h", i, vecs[i].un, vecs[i].a, vecs[i].b),
                  less, vecs[i].exp_less);
            check($sformatf("equal[%0d] un=%b a=%h b=%h", i, vecs[i].un, vecs[i].a, vecs[i].b),
                  equal, vecs[i].exp_eq);
            check($sformatf("exclusive[%0d]", i), less & equal, 1'b0);
        end

        // registered path: held in reset
        @(negedge clk);
        rs1   = 32'h12345678;
        rs2   = 32'h12345678;
        br_un = 1'b0;
        @(posedge clk);
        #1;
        check("reset less_q", less_q, 1'b0);
        check("reset equal_q", equal_q, 1'b0);

        // release reset between edges; first update on next rising edge
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pre-edge equal_q", equal_q, 1'b0);
        @(posedge clk);
        #1;
        check("first edge equal_q", equal_q, 1'b1);
        check("first edge less_q", less_q, 1'b0);

        // operands change; registered flags follow one cycle later
        @(negedge clk);
        rs1   = 32'hFFFFFFFF;
        rs2   = 32'h00000001;
        br_un = 1'b0;
        #1;
        check("hold equal_q before edge", equal_q, 1'b1);
        @(posedge clk);
        #1;
        check("second edge less_q", less_q, 1'b1);
        check("second edge equal_q", equal_q, 1'b0);

        // equal again, then asynchronous reset between edges
        @(negedge clk);
        rs1 = 32'hA5A5A5A5;
        rs2 = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        check("third edge equal_q", equal_q, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset equal_q", equal_q, 1'b0);
        check("async reset less_q", less_q, 1'b0);
        check("comb equal during reset", equal, 1'b1);
        @(posedge clk);
        #1;
        check("held reset equal_q", equal_q, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/br_comp.md
# br_comp

Branch comparator for the single-cycle RISC-V core. Compares the two register-file read operands (rs1, rs2) and reports equality and less-than, signed or unsigned, to the branch-decision logic. The compare result is purely combinational, so branches resolve in the same cycle. A registered copy of both flags is also provided for debug and trace, clocked by the core clock.

## Interface
- No parameters; operand width fixed at 32 bits.
- i_clk  input  1  core clock; used only by the registered flag copies.
- i_rst  input  1  asynchronous, active-high reset; clears the registered flags only.
- i_rs1_data  input  32  first operand (rs1).
- i_rs2_data  input  32  second operand (rs2).
- i_br_un  input  1  1 = unsigned compare (BLTU/BGEU); 0 = signed two's-complement compare (BLT/BGE).
- o_br_less  output  1  combinational: rs1 < rs2 under the selected signedness.
- o_br_equal  output  1  combinational: rs1 == rs2, bit-for-bit.
- o_br_less_q  output  1  o_br_less registered on rising i_clk.
- o_br_equal_q  output  1  o_br_equal registered on rising i_clk.

## Operation
- o_br_equal = 1 iff all 32 bits of i_rs1_data and i_rs2_data match. It is independent of i_br_un.
- Unsigned mode (i_br_un=1): o_br_less = 1 iff rs1 < rs2 as 32-bit unsigned values.
- Signed mode (i_br_un=0): o_br_less = 1 iff rs1 < rs2 as 32-bit two's-complement values.
  - If the sign bits (bit 31) differ, the operand with bit31=1 is the lesser.
  - If the sign bits match, the result equals the unsigned compare of bits [30:0].
- Implementation is structural; no built-in relational operators (<, >, $signed compare).
  - Compare in 4-bit slices. Each slice produces eq and lt for unsigned magnitude.
  - Combine the slices in a tree toward the MSB: lt = lt_hi | (eq_hi & lt_lo); eq = eq_hi & eq_lo.
  - Apply the sign correction at the top level.
- o_br_less and o_br_equal are never both 1.
- X-free: for fully known inputs, both outputs are known (0 or 1).
- Registered copies: on each rising i_clk, o_br_less_q <= o_br_less and o_br_equal_q <= o_br_equal.

## Timing
- o_br_less and o_br_equal:
  - zero-cycle latency; combinational from i_rs1_data, i_rs2_data and i_br_un;
  - valid within the same delta/settle time (a bench samples 1 time unit after applying inputs);
  - no dependence on i_clk or i_rst.
- o_br_less_q and o_br_equal_q:
  - one-cycle latency;
  - reset value 0 for both, applied asynchronously while i_rst=1;
  - first update on the first rising i_clk after i_rst deasserts.
- Reset asserted mid-operation: the registered flags clear immediately. The combinational flags are unaffected.
- No handshake; inputs can change every cycle.

## Test plan
- Unsigned zero case: i_br_un=1, rs1=0x00000000, rs2=0x00000000 -> equal=1, less=0.
- Unsigned extremes:
  - i_br_un=1, rs1=0xFFFFFFFF, rs2=0x00000000 -> equal=0, less=0.
  - Swap the operands -> less=1.
- Signed boundary:
  - i_br_un=0, rs1=0x80000000, rs2=0x7FFFFFFF -> equal=0, less=1.
  - Same operands with i_br_un=1 -> less=0.
- Signed equal negatives: i_br_un=0, rs1=rs2=0xFFFFFFFF -> equal=1, less=0.
  - Also i_br_un=0, rs1=0xFFFFFFFF (-1), rs2=0x00000001 -> less=1.
- Random sweep:
  - 5 unsigned and 10 signed random pairs (include pairs that differ only in bit 31 and only in bit 0).
  - Check against the reference model: equal=(a==b); less=unsigned or signed a<b per i_br_un.
- Registered path:
  - Hold i_rst=1 -> o_br_less_q=0, o_br_equal_q=0.
  - Release reset with rs1=rs2=0x12345678 -> o_br_equal_q=1 after the first rising i_clk.
  - Assert i_rst asynchronously between edges -> o_br_equal_q drops to 0 immediately.
